pingpong_operand_buffer: RTL and testbench
==========================================

Name: pingpong_operand_buffer

Overview:
Double-banked (ping-pong) operand buffer that sits directly upstream of mux2to1 in the Matrix Processing Unit datapath.
- A producer fills one bank of `depth` words while the consumer drains the other.
- The block drives the two bank read words and the bank select straight into mux2to1 `in0`/`in1`/`sel`. The mux output is the consumer's read data.
- Purpose: overlap matrix row/column loading with computation.

Parameters:
num_bits, 8, width of each data word (matches mux2to1 `num_bits`)
depth, 4, words per bank; power of 2, >= 2

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
wr_valid  input  1  producer has a word on wr_data
wr_ready  output  1  buffer can accept a word this cycle
wr_data  input  num_bits  write word
rd_valid  output  1  current read word (mux output) is valid
rd_ready  input  1  consumer accepts current read word
rd_last  output  1  current read word is the final word of its bank
bank0_data  output  num_bits  bank0[rd_idx]; drives mux2to1 in0
bank1_data  output  num_bits  bank1[rd_idx]; drives mux2to1 in1
rd_sel  output  1  bank being read; drives mux2to1 sel
bank_full  output  2  bit b = bank b full (status)

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high. On reset every register clears:
  - both banks' storage
  - `full[1:0]`, `wr_bank`, `wr_idx`, `rd_idx`, `rd_sel`
- Outputs immediately after reset: `wr_ready`=1, `rd_valid`=0, `rd_last`=0, `rd_sel`=0, `bank0_data`=`bank1_data`=0, `bank_full`=2'b00.
- Reset mid-operation discards all buffered words. There is no partial-bank recovery.
- Write side:
  - `wr_ready` = !full[wr_bank], combinational from registers only, with no dependence on `wr_valid`.
  - A write is accepted on `wr_valid && wr_ready`. The word stores to `bank[wr_bank][wr_idx]`.
  - If `wr_idx` != depth-1, `wr_idx`++.
  - If `wr_idx` == depth-1: set `full[wr_bank]`, toggle `wr_bank`, and set `wr_idx`=0.
- Read side:
  - `rd_valid` = full[rd_sel].
  - `bank0_data`/`bank1_data` are combinational reads of the bank registers at `rd_idx`. No read latency beyond the register.
  - `rd_last` = rd_valid && (rd_idx == depth-1).
  - A read is accepted on `rd_valid && rd_ready`.
  - If not the last word, `rd_idx`++.
  - If `rd_last`: clear `full[rd_sel]`, toggle `rd_sel`, and set `rd_idx`=0.
  - While `rd_valid`=0, `rd_sel` and `rd_idx` hold.
- Latency:
  - The word that completes a bank is readable in the cycle after it is accepted (`full` sets at that edge).
  - A drained bank is writable in the cycle after its last read is accepted.
- Conflicts:
  - Write and read can never touch the same bank in the same cycle: writes target a non-full bank, reads target a full bank.
  - Simultaneous bank completion on the write side and bank drain on the read side both take effect on the same edge.
- Full/empty:
  - Both banks full: `wr_ready`=0, and `wr_data` is ignored.
  - Both banks empty: `rd_valid`=0, and `bank*_data` show stale or zero contents, which the consumer must ignore.
- Ordering: words exit in exact write order. Banks alternate 0,1,0,1,… on both sides.
- Throughput: 1 word/cycle sustained once the first bank is full.
- Wrap-around: `wr_idx`/`rd_idx` wrap depth-1→0 only on bank switch. Pointer width = clog2(depth).

Test Plan:
- Reset: assert `rst` 2 cycles → `wr_ready`=1, `rd_valid`=0, `rd_sel`=0, `bank_full`=00, `bank0_data`=`bank1_data`=0x00.
- Fill bank0 with `rd_ready`=0: write 0x11,0x12,0x13,0x14 → `bank_full`=01 and `rd_valid`=1 on the cycle after 0x14 is accepted. `rd_sel`=0, mux out=`bank0_data`=0x11, `wr_ready` stays 1.
- Both banks full, back-pressure: continue with 0x21..0x24 → `bank_full`=11, `wr_ready`=0. A 9th write of 0xFF held for 5 cycles is not stored.
- Drain through mux2to1 with `rd_ready`=1 → mux out 0x11,0x12,0x13,0x14 with `rd_last` on 0x14. Next cycle: `rd_sel`=1 and `wr_ready`=1. Then 0x21..0x24 with `rd_last` on 0x24, then `rd_valid`=0, `rd_sel`=0.
- Streaming: `wr_valid`=1 with incrementing data 0x00..0x0F and `rd_ready`=1 continuously → mux out 0x00..0x0F in order, no drops or duplicates. First `rd_valid` arrives 4 cycles after the first write; after that one word per cycle.
- Reset mid-operation: after bank0 is full, 1 word read and 2 words written to bank1, assert `rst` → all status returns to reset values. A following write of 0x55 lands in bank0 index 0.

Source files
------------

// File: rtl/pingpong_operand_buffer_if.sv
// Producer/consumer bundle for the ping-pong operand buffer, including the
// bank read words and select that feed the downstream 2:1 mux.
interface pingpong_operand_buffer_if #(
  parameter int unsigned num_bits = 8
);
  logic                wr_valid;
  logic                wr_ready;
  logic [num_bits-1:0] wr_data;
  logic                rd_valid;
  logic                rd_ready;
  logic                rd_last;
  logic [num_bits-1:0] bank0_data;
  logic [num_bits-1:0] bank1_data;
  logic                rd_sel;
  logic [1:0]          bank_full;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_last, bank0_data, bank1_data, rd_sel, bank_full
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_last, bank0_data, bank1_data, rd_sel, bank_full
  );
endinterface

// File: rtl/pingpong_operand_buffer.sv
// Two-bank operand buffer: the producer fills one bank while the consumer drains
// the other; both bank words at rd_idx and the bank select go straight to a mux.
module pingpong_operand_buffer #(
  parameter int unsigned num_bits = 8,
  parameter int unsigned depth    = 4
) (
  input logic                      clk,
  input logic                      rst,
  pingpong_operand_buffer_if.slave bus
);
  localparam int unsigned idx_bits = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [idx_bits-1:0] last_idx = idx_bits'(depth - 1);

  logic [num_bits-1:0] mem_q [2][depth];
  logic [1:0]          full_q, full_d;
  logic                wr_bank_q, rd_sel_q;
  logic [idx_bits-1:0] wr_idx_q, rd_idx_q;
  logic                rd_valid, wr_fire, rd_fire, wr_done, rd_done;

  // Writes only target a non-full bank and reads only a full one, so the two
  // updates to full_d never collide on the same bit.
  always_comb begin
    rd_valid = full_q[rd_sel_q];
    wr_fire  = bus.wr_valid && !full_q[wr_bank_q];
    rd_fire  = rd_valid && bus.rd_ready;
    wr_done  = wr_fire && (wr_idx_q == last_idx);
    rd_done  = rd_fire && (rd_idx_q == last_idx);
    full_d   = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_sel_q]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(depth); i++) begin
          mem_q[b][i] <= '0;
        end
      end
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_sel_q  <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      full_q <= full_d;
      if (wr_fire) begin
        mem_q[wr_bank_q][wr_idx_q] <= bus.wr_data;
        if (wr_done) begin
          wr_bank_q <= ~wr_bank_q;
          wr_idx_q  <= '0;
        end else begin
          wr_idx_q <= wr_idx_q + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_done) begin
          rd_sel_q <= ~rd_sel_q;
          rd_idx_q <= '0;
        end else begin
          rd_idx_q <= rd_idx_q + 1'b1;
        end
      end
    end
  end

  assign bus.wr_ready   = !full_q[wr_bank_q];
  assign bus.rd_valid   = rd_valid;
  assign bus.rd_last    = rd_valid && (rd_idx_q == last_idx);
  assign bus.bank0_data = mem_q[0][rd_idx_q];
  assign bus.bank1_data = mem_q[1][rd_idx_q];
  assign bus.rd_sel     = rd_sel_q;
  assign bus.bank_full  = full_q;
endmodule

// File: tb/tb_pingpong_operand_buffer.sv
// Scoreboard bench for pingpong_operand_buffer: words are queued as writes are
// accepted and compared against the mux2to1-equivalent output as reads fire.
module tb_pingpong_operand_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  pingpong_operand_buffer_if #(.num_bits(8)) bus ();

  pingpong_operand_buffer #(.num_bits(8), .depth(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive one cycle, report what the DUT would accept before the edge.
  task automatic tick(input logic wv, input logic [7:0] wd, input logic rr,
                      output logic wf, output logic rf, output logic [7:0] word,
                      output logic last);
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    #1;
    wf   = wv && bus.wr_ready;
    rf   = bus.rd_valid && rr;
    word = bus.rd_sel ? bus.bank1_data : bus.bank0_data;
    last = bus.rd_last;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic wf, rf, last;
    logic [7:0] word;
    rst = 1'b1;
    tick(1'b0, 8'h00, 1'b0, wf, rf, word, last);
    tick(1'b0, 8'h00, 1'b0, wf, rf, word, last);
    rst = 1'b0;
    sb.delete();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset wr_ready got=%b exp=1", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_last !== 1'b0) begin errors++; $display("FAIL reset rd_last got=%b exp=0", bus.rd_last); end
    checks++; if (bus.rd_sel !== 1'b0) begin errors++; $display("FAIL reset rd_sel got=%b exp=0", bus.rd_sel); end
    checks++; if (bus.bank_full !== 2'b00) begin errors++; $display("FAIL reset bank_full got=%b exp=00", bus.bank_full); end
    checks++; if (bus.bank0_data !== 8'h00) begin errors++; $display("FAIL reset bank0_data got=%h exp=00", bus.bank0_data); end
    checks++; if (bus.bank1_data !== 8'h00) begin errors++; $display("FAIL reset bank1_data got=%h exp=00", bus.bank1_data); end
  endtask

  task automatic test_fill_bank0();
    logic wf, rf, last;
    logic [7:0] word;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 8'h11 + 8'(i), 1'b0, wf, rf, word, last);
      checks++; if (wf !== 1'b1) begin errors++; $display("FAIL fill accept[%0d] got=%b exp=1", i, wf); end
      if (wf) sb.push_back(8'h11 + 8'(i));
      if (i == 2) begin
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL fill early rd_valid got=%b exp=0", bus.rd_valid); end
      end
    end
    bus.wr_valid = 1'b0;
    checks++; if (bus.bank_full !== 2'b01) begin errors++; $display("FAIL fill bank_full got=%b exp=01", bus.bank_full); end
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL fill rd_valid got=%b exp=1", bus.rd_valid); end
    checks++; if (bus.rd_sel !== 1'b0) begin errors++; $display("FAIL fill rd_sel got=%b exp=0", bus.rd_sel); end
    checks++; if (bus.bank0_data !== 8'h11) begin errors++; $display("FAIL fill mux_out got=%h exp=11", bus.bank0_data); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL fill wr_ready got=%b exp=1", bus.wr_ready); end
  endtask

  task automatic test_backpressure();
    logic wf, rf, last;
    logic [7:0] word;
    int extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 8'h21 + 8'(i), 1'b0, wf, rf, word, last);
      checks++; if (wf !== 1'b1) begin errors++; $display("FAIL bp accept[%0d] got=%b exp=1", i, wf); end
      if (wf) sb.push_back(8'h21 + 8'(i));
    end
    checks++; if (bus.bank_full !== 2'b11) begin errors++; $display("FAIL bp bank_full got=%b exp=11", bus.bank_full); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL bp wr_ready got=%b exp=0", bus.wr_ready); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'hFF, 1'b0, wf, rf, word, last);
      if (wf) extra++;
    end
    bus.wr_valid = 1'b0;
    checks++; if (extra !== 0) begin errors++; $display("FAIL bp ninth_write accepted=%0d exp=0", extra); end
  endtask

  task automatic test_drain();
    logic wf, rf, last;
    logic [7:0] word, exp;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 1'b1, wf, rf, word, last);
      checks++; if (rf !== 1'b1) begin errors++; $display("FAIL drain rd_fire[%0d] got=%b exp=1", i, rf); end
      if (rf) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
        checks++; if (word !== exp) begin errors++; $display("FAIL drain word[%0d] got=%h exp=%h", i, word, exp); end
        checks++; if (last !== (i % 4 == 3)) begin errors++; $display("FAIL drain rd_last[%0d] got=%b exp=%b", i, last, (i % 4 == 3)); end
      end
      if (i == 3) begin
        checks++; if (bus.rd_sel !== 1'b1) begin errors++; $display("FAIL drain switch rd_sel got=%b exp=1", bus.rd_sel); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL drain switch wr_ready got=%b exp=1", bus.wr_ready); end
      end
    end
    bus.rd_ready = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL drain end rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_sel !== 1'b0) begin errors++; $display("FAIL drain end rd_sel got=%b exp=0", bus.rd_sel); end
    checks++; if (bus.bank_full !== 2'b00) begin errors++; $display("FAIL drain end bank_full got=%b exp=00", bus.bank_full); end
  endtask

  task automatic test_streaming();
    logic wf, rf, last;
    logic [7:0] word, exp;
    int next_wr = 0, reads = 0, first_rd = -1, last_rd = -1, stalls = 0, bad = 0;
    for (int t = 0; t < 40 && reads < 16; t++) begin
      tick(next_wr < 16, 8'(next_wr), 1'b1, wf, rf, word, last);
      if (next_wr < 16 && !wf) stalls++;
      if (wf) begin
        sb.push_back(8'(next_wr));
        next_wr++;
      end
      if (rf) begin
        if (first_rd < 0) first_rd = t;
        last_rd = t;
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
        if (word !== exp) begin
          bad++;
          $display("FAIL stream word[%0d] got=%h exp=%h", reads, word, exp);
        end
        reads++;
      end
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    checks++; if (bad !== 0) errors++;
    checks++; if (reads !== 16) begin errors++; $display("FAIL stream reads got=%0d exp=16", reads); end
    checks++; if (first_rd !== 4) begin errors++; $display("FAIL stream first_rd cycle got=%0d exp=4", first_rd); end
    checks++; if (last_rd !== 19) begin errors++; $display("FAIL stream last_rd cycle got=%0d exp=19", last_rd); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL stream write_stalls got=%0d exp=0", stalls); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL stream leftover got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    logic wf, rf, last;
    logic [7:0] word;
    for (int i = 0; i < 4; i++) tick(1'b1, 8'h41 + 8'(i), 1'b0, wf, rf, word, last);
    tick(1'b1, 8'h51, 1'b1, wf, rf, word, last);
    checks++; if (!(wf && rf)) begin errors++; $display("FAIL mid overlap wf=%b rf=%b exp=1/1", wf, rf); end
    tick(1'b1, 8'h52, 1'b0, wf, rf, word, last);
    bus.wr_valid = 1'b0;
    rst = 1'b1;
    tick(1'b0, 8'h00, 1'b0, wf, rf, word, last);
    rst = 1'b0;
    sb.delete();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL mid wr_ready got=%b exp=1", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL mid rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_sel !== 1'b0) begin errors++; $display("FAIL mid rd_sel got=%b exp=0", bus.rd_sel); end
    checks++; if (bus.bank_full !== 2'b00) begin errors++; $display("FAIL mid bank_full got=%b exp=00", bus.bank_full); end
    checks++; if (bus.bank0_data !== 8'h00) begin errors++; $display("FAIL mid bank0_data got=%h exp=00", bus.bank0_data); end
    checks++; if (bus.bank1_data !== 8'h00) begin errors++; $display("FAIL mid bank1_data got=%h exp=00", bus.bank1_data); end
    tick(1'b1, 8'h55, 1'b0, wf, rf, word, last);
    bus.wr_valid = 1'b0;
    checks++; if (bus.bank0_data !== 8'h55) begin errors++; $display("FAIL mid post_write bank0[0] got=%h exp=55", bus.bank0_data); end
    checks++; if (bus.bank1_data !== 8'h00) begin errors++; $display("FAIL mid post_write bank1[0] got=%h exp=00", bus.bank1_data); end
    checks++; if (bus.bank_full !== 2'b00) begin errors++; $display("FAIL mid post_write bank_full got=%b exp=00", bus.bank_full); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rd_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_bank0();
    test_backpressure();
    test_drain();
    test_streaming();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
